// File: rtl/npu_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// npu_load_ctrl_if
//
// Bundles the signals around the NPU load controller:
//   host bus      : chipselect, write, read, address[1:0], writedata[31:0]
//                   (host -> controller), readdata[31:0] (controller -> host)
//   memory load   : load_valid, load_phase[1:0], load_addr[14:0],
//                   load_data[31:0] (controller -> weight/image memories)
//   compute hooks : npu_start, irq (controller -> system),
//                   npu_done (NPU core -> controller)
//
// Modports:
//   slave  : the controller's view (npu_load_ctrl)
//   master : the host / system view (bus master, testbench)
//
// Clock and reset are kept out of the interface and stay plain ports.
// -----------------------------------------------------------------------------
interface npu_load_ctrl_if;

    // Host register bus
    logic        chipselect;
    logic        write;
    logic        read;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    // Memory load stream
    logic        load_valid;
    logic [1:0]  load_phase;
    logic [14:0] load_addr;
    logic [31:0] load_data;

    // Compute control
    logic        npu_start;
    logic        npu_done;
    logic        irq;

    modport slave (
        input  chipselect,
        input  write,
        input  read,
        input  address,
        input  writedata,
        output readdata,
        output load_valid,
        output load_phase,
        output load_addr,
        output load_data,
        output npu_start,
        input  npu_done,
        output irq
    );

    modport master (
        output chipselect,
        output write,
        output read,
        output address,
        output writedata,
        input  readdata,
        input  load_valid,
        input  load_phase,
        input  load_addr,
        input  load_data,
        input  npu_start,
        output npu_done,
        input  irq
    );

endinterface : npu_load_ctrl_if

// File: rtl/npu_load_ctrl.sv
// -----------------------------------------------------------------------------
// npu_load_ctrl
//
// Host-driven loader and sequencer for a small NPU. The host arms the block,
// streams image words, conv weight bytes and dense weight words through the
// DATA register, and each accepted word is re-issued one cycle later as a
// single-cycle memory write (load_valid / load_phase / load_addr / load_data).
// Once all three phases are full the block waits in READY for a start command,
// pulses npu_start, waits for npu_done and then holds irq until the host
// clears it.
//
// Parameters:
//   IMG_WORDS   : image words per load           (default 225)
//   CONV_BYTES  : conv weight bytes per load     (default 18816, <= 32768)
//   DENSE_WORDS : dense weight words per load    (default 4203)
//
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : npu_load_ctrl_if.slave
//           host registers (address): 0 CTRL, 1 DATA, 2 STATUS, 3 COUNT
//           CTRL bits: [3] abort, [0] arm, [1] start, [2] irq_clear
//           STATUS   : {27'b0, irq, err, state[2:0]}
//           COUNT    : {17'b0, counter[14:0]}
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module npu_load_ctrl #(
    parameter int IMG_WORDS   = 225,
    parameter int CONV_BYTES  = 18816,
    parameter int DENSE_WORDS = 4203
) (
    input  logic                 clk,
    input  logic                 reset,
    npu_load_ctrl_if.slave       bus
);

    // Host register map
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    // Counter value of the last word in each phase. The counter is 15 bits
    // wide and is cleared on the last word, so it never wraps as long as
    // every phase length fits in 32768 entries.
    localparam logic [14:0] IMG_LAST   = 15'(IMG_WORDS - 1);
    localparam logic [14:0] CONV_LAST  = 15'(CONV_BYTES - 1);
    localparam logic [14:0] DENSE_LAST = 15'(DENSE_WORDS - 1);

    // The encoding is host-visible through STATUS, so the values are fixed.
    // The LOAD_* encodings double as the load_phase tag (1 image, 2 conv,
    // 3 dense).
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_IMG   = 3'd1,
        LOAD_CONV  = 3'd2,
        LOAD_DENSE = 3'd3,
        READY      = 3'd4,
        RUN        = 3'd5,
        DONE       = 3'd6
    } state_t;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t      state;
    logic [14:0] counter;
    logic        err;
    logic        irq_q;
    logic        load_valid_q;
    logic [1:0]  load_phase_q;
    logic [14:0] load_addr_q;
    logic [31:0] load_data_q;
    logic        npu_start_q;
    logic [31:0] readdata_q;

    // -------------------------------------------------------------------------
    // Host strobe decode
    // -------------------------------------------------------------------------
    logic host_wr;
    logic wr_ctrl;
    logic wr_data;
    logic rd_en;
    logic ctrl_abort;
    logic ctrl_arm;
    logic ctrl_start;
    logic ctrl_clear;

    assign host_wr    = bus.chipselect & bus.write;
    assign wr_ctrl    = host_wr & (bus.address == REG_CTRL);
    assign wr_data    = host_wr & (bus.address == REG_DATA);
    assign rd_en      = bus.chipselect & bus.read;

    assign ctrl_abort = bus.writedata[3];
    assign ctrl_arm   = bus.writedata[0];
    assign ctrl_start = bus.writedata[1];
    assign ctrl_clear = bus.writedata[2];

    // -------------------------------------------------------------------------
    // Per-phase terminal count, successor state and load word formatting
    // -------------------------------------------------------------------------
    logic [14:0] phase_last;
    state_t      phase_next;
    logic [31:0] load_word;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        phase_last = IMG_LAST;
        phase_next = LOAD_CONV;
        load_word  = bus.writedata;
        case (state)
            LOAD_IMG: begin
                phase_last = IMG_LAST;
                phase_next = LOAD_CONV;
            end
            LOAD_CONV: begin
                phase_last = CONV_LAST;
                phase_next = LOAD_DENSE;
                // Conv weights are byte-wide; only the low byte is stored.
                load_word  = {24'b0, bus.writedata[7:0]};
            end
            LOAD_DENSE: begin
                phase_last = DENSE_LAST;
                phase_next = READY;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Read data mux (registered below)
    // -------------------------------------------------------------------------
    logic [31:0] read_mux;

    always_comb begin
        read_mux = 32'b0;
        case (bus.address)
            REG_STATUS: read_mux = {27'b0, irq_q, err, state};
            REG_COUNT:  read_mux = {17'b0, counter};
            default:    read_mux = 32'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Controller FSM with registered outputs
    //
    // CTRL priority is abort > arm > start > clear. The states in which each
    // command is legal do not overlap except for abort and start in READY, so
    // checking abort first in READY is enough to honour the priority; an
    // illegal higher-priority bit never masks a legal lower one.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            counter      <= '0;
            err          <= 1'b0;
            irq_q        <= 1'b0;
            load_valid_q <= 1'b0;
            load_phase_q <= 2'd0;
            load_addr_q  <= '0;
            load_data_q  <= '0;
            npu_start_q  <= 1'b0;
            readdata_q   <= '0;
        end else begin
            // Strobes default low; the load fields hold their last value and
            // are only meaningful alongside load_valid.
            load_valid_q <= 1'b0;
            npu_start_q  <= 1'b0;

            if (rd_en) begin
                readdata_q <= read_mux;
            end

            case (state)
                IDLE: begin
                    if (wr_ctrl && ctrl_arm) begin
                        state   <= LOAD_IMG;
                        counter <= '0;
                        err     <= 1'b0;
                    end else if (wr_data) begin
                        err <= 1'b1;
                    end
                end

                LOAD_IMG, LOAD_CONV, LOAD_DENSE: begin
                    if (wr_ctrl && ctrl_abort) begin
                        state   <= IDLE;
                        counter <= '0;
                    end else if (wr_data) begin
                        load_valid_q <= 1'b1;
                        load_phase_q <= state[1:0];
                        load_addr_q  <= counter;
                        load_data_q  <= load_word;
                        // The last word keeps its own phase tag and address;
                        // the following phase starts again at address 0.
                        if (counter == phase_last) begin
                            counter <= '0;
                            state   <= phase_next;
                        end else begin
                            counter <= counter + 15'd1;
                        end
                    end
                end

                READY: begin
                    if (wr_ctrl && ctrl_abort) begin
                        state   <= IDLE;
                        counter <= '0;
                    end else if (wr_ctrl && ctrl_start) begin
                        npu_start_q <= 1'b1;
                        state       <= RUN;
                    end else if (wr_data) begin
                        err <= 1'b1;
                    end
                end

                RUN: begin
                    // npu_done is only looked at once the start pulse is over,
                    // so a done level left over from a previous job cannot end
                    // this one on the pulse cycle itself.
                    if (!npu_start_q && bus.npu_done) begin
                        state <= DONE;
                        irq_q <= 1'b1;
                    end
                    if (wr_data) begin
                        err <= 1'b1;
                    end
                end

                DONE: begin
                    if (wr_ctrl && ctrl_clear) begin
                        irq_q <= 1'b0;
                        state <= IDLE;
                    end else if (wr_data) begin
                        err <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    assign bus.readdata   = readdata_q;
    assign bus.load_valid = load_valid_q;
    assign bus.load_phase = load_phase_q;
    assign bus.load_addr  = load_addr_q;
    assign bus.load_data  = load_data_q;
    assign bus.npu_start  = npu_start_q;
    assign bus.irq        = irq_q;

endmodule : npu_load_ctrl

// File: tb/tb_npu_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_npu_load_ctrl
//
// Directed bench for npu_load_ctrl with default parameters. Every cycle goes
// through tick(), which applies one set of host inputs and, on the clock edge,
// advances a behavioural model of the controller (integer state number,
// integer counter, per-phase length table). A negedge process compares every
// output against the model on every cycle after reset, and the directed
// sequences add literal expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_npu_load_ctrl;

    localparam int IMG   = 225;
    localparam int CONV  = 18816;
    localparam int DENSE = 4203;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    npu_load_ctrl_if bus ();

    npu_load_ctrl #(
        .IMG_WORDS   (IMG),
        .CONV_BYTES  (CONV),
        .DENSE_WORDS (DENSE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // -------------------------------------------------------------------------
    // Check bookkeeping
    // -------------------------------------------------------------------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // States as plain integers 0..6 (IDLE, LOAD_IMG, LOAD_CONV, LOAD_DENSE,
    // READY, RUN, DONE); in a load state the state number is the phase tag.
    // -------------------------------------------------------------------------
    int          lim [4] = '{0, IMG, CONV, DENSE};
    int          m_state = 0;
    int          m_count = 0;
    bit          m_err   = 1'b0;
    bit          m_irq   = 1'b0;

    logic        exp_valid = 1'b0;
    logic [1:0]  exp_phase = '0;
    logic [14:0] exp_addr  = '0;
    logic [31:0] exp_data  = '0;
    logic        exp_start = 1'b0;
    logic [31:0] exp_rdata = '0;

    task automatic model_step(input logic cs, input logic wr, input logic rd,
                              input logic [1:0] a, input logic [31:0] wd,
                              input logic done, input logic rst);
        logic pulse_now;
        pulse_now = exp_start;
        exp_valid = 1'b0;
        exp_start = 1'b0;
        if (!rst) begin
            m_state   = 0;
            m_count   = 0;
            m_err     = 1'b0;
            m_irq     = 1'b0;
            exp_phase = '0;
            exp_addr  = '0;
            exp_data  = '0;
            exp_rdata = '0;
        end else begin
            // Reads return the values from before this edge.
            if (cs && rd) begin
                if (a == 2'd2)      exp_rdata = {27'b0, m_irq, m_err, 3'(m_state)};
                else if (a == 2'd3) exp_rdata = 32'(m_count);
                else                exp_rdata = 32'b0;
            end
            if (m_state == 5 && !pulse_now && done) begin
                m_state = 6;
                m_irq   = 1'b1;
            end
            if (cs && wr && a == 2'd0) begin
                if (wd[3] && m_state >= 1 && m_state <= 4) begin
                    m_state = 0;
                    m_count = 0;
                end else if (wd[0] && m_state == 0) begin
                    m_state = 1;
                    m_count = 0;
                    m_err   = 1'b0;
                end else if (wd[1] && m_state == 4) begin
                    exp_start = 1'b1;
                    m_state   = 5;
                end else if (wd[2] && m_state == 6) begin
                    m_irq   = 1'b0;
                    m_state = 0;
                end
            end else if (cs && wr && a == 2'd1) begin
                if (m_state >= 1 && m_state <= 3) begin
                    exp_valid = 1'b1;
                    exp_phase = 2'(m_state);
                    exp_addr  = 15'(m_count);
                    exp_data  = (m_state == 2) ? (wd & 32'h0000_00FF) : wd;
                    m_count++;
                    if (m_count == lim[m_state]) begin
                        m_state++;
                        m_count = 0;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus primitives: one call = one clock cycle
    // -------------------------------------------------------------------------
    task automatic tick(input logic cs, input logic wr, input logic rd,
                        input logic [1:0] a, input logic [31:0] wd,
                        input logic done, input logic rst);
        bus.chipselect = cs;
        bus.write      = wr;
        bus.read       = rd;
        bus.address    = a;
        bus.writedata  = wd;
        bus.npu_done   = done;
        reset          = rst;
        @(posedge clk);
        model_step(cs, wr, rd, a, wd, done, rst);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        tick(1'b1, 1'b1, 1'b0, a, d, 1'b0, 1'b1);
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
        tick(1'b1, 1'b0, 1'b1, a, 32'h0, 1'b0, 1'b1);
        v = bus.readdata;
    endtask

    // -------------------------------------------------------------------------
    // Per-cycle compare against the model, plus load-stream statistics
    // -------------------------------------------------------------------------
    bit          cmp_en = 1'b0;
    int          n_words [4] = '{0, 0, 0, 0};
    int          n_start = 0;
    bit          have_prev = 1'b0;
    logic [1:0]  prev_phase = '0;
    logic [14:0] prev_addr = '0;
    logic [14:0] sw_last_addr = '1;
    logic [14:0] sw_first_addr = '1;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("load_valid", 32'(bus.load_valid), 32'(exp_valid));
            check("load_phase", 32'(bus.load_phase), 32'(exp_phase));
            check("load_addr",  32'(bus.load_addr),  32'(exp_addr));
            check("load_data",  bus.load_data,       exp_data);
            check("npu_start",  32'(bus.npu_start),  32'(exp_start));
            check("irq",        32'(bus.irq),        32'(m_irq));
            check("readdata",   bus.readdata,        exp_rdata);
            if (bus.npu_start === 1'b1) n_start++;
            if (bus.load_valid === 1'b1) begin
                n_words[bus.load_phase]++;
                if (have_prev && prev_phase == 2'd1 && bus.load_phase == 2'd2) begin
                    sw_last_addr  = prev_addr;
                    sw_first_addr = bus.load_addr;
                end
                prev_phase = bus.load_phase;
                prev_addr  = bus.load_addr;
                have_prev  = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Directed sequences
    // -------------------------------------------------------------------------
    logic [31:0] v;
    int          base [4];
    int          base_start;

    initial begin
        // Reset
        tick(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        rd_reg(2'd2, v);
        check("reset_status", v, 32'h0000_0000);

        // Stray DATA write in IDLE sets err; arm clears it
        wr_reg(2'd1, 32'h1234_5678);
        check("stray_no_valid", 32'(bus.load_valid), 32'h0);
        rd_reg(2'd2, v);
        check("stray_status", v, 32'h0000_0008);
        wr_reg(2'd0, 32'h1);
        rd_reg(2'd2, v);
        check("arm_clears_err", v, 32'h0000_0001);

        // Priority: 0xB in LOAD_IMG aborts only; 0x3 in IDLE arms only
        wr_reg(2'd0, 32'hB);
        rd_reg(2'd2, v);
        check("prio_abort", v, 32'h0000_0000);
        base_start = n_start;
        wr_reg(2'd0, 32'h3);
        idle(2);
        rd_reg(2'd2, v);
        check("prio_arm", v, 32'h0000_0001);
        check("prio_no_start", 32'(n_start - base_start), 32'd0);

        // Abort after 100 conv writes, then re-arm and write one word
        for (int i = 0; i < IMG; i++) wr_reg(2'd1, 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 100; i++) wr_reg(2'd1, 32'h0000_0100 + 32'(i));
        rd_reg(2'd3, v);
        check("conv_count_100", v, 32'd100);
        wr_reg(2'd0, 32'h8);
        rd_reg(2'd2, v);
        check("abort_state", v, 32'h0000_0000);
        rd_reg(2'd3, v);
        check("abort_count", v, 32'h0000_0000);
        wr_reg(2'd0, 32'h1);
        wr_reg(2'd1, 32'hCAFE_0001);
        check("rearm_phase", 32'(bus.load_phase), 32'd1);
        check("rearm_addr",  32'(bus.load_addr),  32'd0);
        check("rearm_data",  bus.load_data,       32'hCAFE_0001);

        // Full load from a fresh arm
        wr_reg(2'd0, 32'h8);
        wr_reg(2'd0, 32'h1);
        for (int p = 0; p < 4; p++) base[p] = n_words[p];
        for (int i = 0; i < IMG + CONV + DENSE; i++)
            wr_reg(2'd1, 32'(i) * 32'h9E37_79B9 + 32'h0000_5A5A);
        idle(1);
        check("img_words",   32'(n_words[1] - base[1]), 32'd225);
        check("conv_words",  32'(n_words[2] - base[2]), 32'd18816);
        check("dense_words", 32'(n_words[3] - base[3]), 32'd4203);
        check("img_last_addr",   32'(sw_last_addr),  32'd224);
        check("conv_first_addr", 32'(sw_first_addr), 32'd0);
        rd_reg(2'd2, v);
        check("ready_status", v, 32'h0000_0004);

        // Start, done after 50 cycles, irq held across abort/arm, then clear
        base_start = n_start;
        wr_reg(2'd0, 32'h2);
        idle(50);
        tick(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
        rd_reg(2'd2, v);
        check("done_status", v, 32'h0000_0016);
        check("start_pulses", 32'(n_start - base_start), 32'd1);
        wr_reg(2'd0, 32'h9);
        rd_reg(2'd2, v);
        check("irq_held", v, 32'h0000_0016);
        wr_reg(2'd0, 32'h4);
        rd_reg(2'd2, v);
        check("clear_status", v, 32'h0000_0000);
        check("clear_irq", 32'(bus.irq), 32'd0);

        // Reset in the middle of LOAD_DENSE
        wr_reg(2'd0, 32'h1);
        for (int i = 0; i < IMG + CONV + 10; i++) wr_reg(2'd1, 32'hF00D_0000 + 32'(i));
        rd_reg(2'd2, v);
        check("dense_status", v, 32'h0000_0003);
        tick(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_load_data", bus.load_data, 32'h0);
        check("rst_ctl_outs",
              32'({bus.npu_start, bus.irq, bus.load_valid, bus.load_phase, bus.load_addr}),
              32'h0);
        rd_reg(2'd2, v);
        check("rst_status", v, 32'h0000_0000);
        wr_reg(2'd0, 32'h1);
        wr_reg(2'd1, 32'hBEEF_0002);
        check("post_rst_phase", 32'(bus.load_phase), 32'd1);
        check("post_rst_addr",  32'(bus.load_addr),  32'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_npu_load_ctrl

// File: doc/npu_load_ctrl.md
NPU_LOAD_CTRL -- requirements
Module: npu_load_ctrl

Interface
REQ-001 SHALL have parameters IMG_WORDS, default 225, image words per load; CONV_BYTES, default 18816, conv weight bytes; DENSE_WORDS, default 4203, dense weight words.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-004 SHALL have ports chipselect, write and read, input, 1 each, host bus strobes; a write or read counts only when chipselect=1.
REQ-005 SHALL have ports address, input, 2, register select: 0 CTRL, 1 DATA, 2 STATUS, 3 COUNT; and writedata, input, 32, host write data.
REQ-006 SHALL have port readdata, output, 32, registered read data.
REQ-007 SHALL have ports load_valid, output, 1, one-cycle memory write strobe; load_phase, output, 2, target (1 image, 2 conv, 3 dense, 0 none); load_addr, output, 15, write address; load_data, output, 32, write word.
REQ-008 SHALL have ports npu_start, output, 1, one-cycle compute start pulse; npu_done, input, 1, compute-finished level or pulse; irq, output, 1, level interrupt.

Function
REQ-009 SHALL implement states IDLE, LOAD_IMG, LOAD_CONV, LOAD_DENSE, READY, RUN and DONE, with STATUS encodings 0 through 6 in that order.
REQ-010 SHALL decode CTRL writes as bit3 abort, bit0 arm, bit1 start, bit2 irq_clear; when several bits are set, SHALL act on abort first, then arm, start and clear, and act on only the highest-priority bit valid in the current state.
REQ-011 SHALL treat abort as valid in LOAD_IMG, LOAD_CONV, LOAD_DENSE and READY: next state IDLE, counter 0, no load_valid issued for that cycle.
REQ-012 SHALL treat arm as valid only in IDLE: next state LOAD_IMG, counter 0, err cleared.
REQ-013 SHALL accept each DATA write in a LOAD_* state: one cycle later, load_valid=1, load_phase = phase of the accepting state, load_addr = counter value before increment, load_data = writedata (conv phase: {24'b0, writedata[7:0]}); counter increments.
REQ-014 SHALL, on the accepted DATA write with counter = IMG_WORDS-1 in LOAD_IMG, move to LOAD_CONV with counter reset to 0 in the same edge; likewise for CONV_BYTES-1 in LOAD_CONV to LOAD_DENSE, and DENSE_WORDS-1 in LOAD_DENSE to READY.
REQ-015 SHALL keep the last word of each phase tagged with its own phase and address (e.g. load_phase=1, load_addr=224); the first word of the next phase SHALL go to address 0.
REQ-016 SHALL ignore DATA writes in IDLE, READY, RUN and DONE: no load_valid, sticky err=1.
REQ-017 SHALL treat start as valid only in READY: npu_start=1 for exactly the next cycle, then state RUN.
REQ-018 SHALL sample npu_done only in RUN, starting the cycle after npu_start: npu_done=1 moves the block to DONE and sets irq=1 on the same edge; npu_done in other states is ignored.
REQ-019 SHALL treat irq_clear as valid only in DONE: irq=0, state IDLE; irq SHALL stay 1 until then, including across abort/arm attempts.
REQ-020 SHALL return readdata one cycle after a read: STATUS = {27'b0, irq, err, state[2:0]}; COUNT = {17'b0, counter[14:0]}; CTRL/DATA read as 0.
REQ-021 SHALL hold the counter at 15 bits and never let it wrap; parameters SHALL satisfy CONV_BYTES ≤ 32768.
REQ-022 SHALL register every output; no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, while reset=0 at a clock edge, set state IDLE, counter 0, err 0, irq 0, load_valid 0, load_phase 0, load_addr 0, load_data 0, npu_start 0 and readdata 0.
REQ-024 SHALL, on reset mid-load or mid-RUN, discard all progress; the next arm restarts the image phase at address 0.

Verification
REQ-025 SHALL be verified for a full load: arm, then 225+18816+4203 DATA writes. Required: load_valid count matches per phase; last image word phase 1 addr 224; first conv phase 2 addr 0; STATUS state 4 after the final write.
REQ-026 SHALL be verified for start and done: CTRL=0x2 in READY gives npu_start high for exactly 1 cycle. npu_done after 50 cycles gives STATUS=0x16 (irq=1, state 6). CTRL=0x4 then gives irq=0 and state 0.
REQ-027 SHALL be verified for abort: CTRL=0x8 after 100 conv writes gives state 0 and COUNT 0. A following arm plus one DATA write gives phase 1 addr 0.
REQ-028 SHALL be verified for a stray write: DATA write in IDLE gives no load_valid and STATUS=0x08. A following arm clears err.
REQ-029 SHALL be verified for priority: CTRL=0xB in LOAD_IMG gives abort only (state 0). CTRL=0x3 in IDLE gives arm only (state 1, no npu_start).
REQ-030 SHALL be verified for reset mid-load: reset=0 for 1 cycle during LOAD_DENSE gives all outputs 0 and STATUS=0 on the following read.
